// File: rtl/hdr_ctrl_pkg.sv
// Shared types and constants for the HDR Exit / HDR Restart pattern controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdr_ctrl_pkg;

    // Fall counter is wide enough to hold EXIT_FALLS, where it saturates.
    localparam int FALL_W = 3;

    localparam logic [FALL_W-1:0] RESTART_FALLS = 3'd2;
    localparam logic [FALL_W-1:0] EXIT_FALLS    = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNT,
        EXIT_WAIT
    } hdr_state_t;

endpackage

// File: rtl/bus_line_sync.sv
// Synchronizes one asynchronous bus line and reports its rise/fall edges.
// Latency: s follows the pin SYNC_STAGES cycles after it is first sampled; rise/fall are combinational from s.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   line       raw asynchronous bus line
//   s          synchronized level
//   rise, fall single-cycle edge flags of s
module bus_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Reset to 1 everywhere: an idle I3C bus is pulled high, so leaving reset
    // with the lines high produces no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/hdr_exit_restart_ctrl.sv
// Arms and classifies HDR Restart / HDR Exit patterns on SCL/SDA while in HDR mode.
// Latency: classified pulse one cycle after the deciding synchronized edge (SYNC_STAGES+1 cycles after the pin change).
// Backpressure: none; pulses are single-cycle and unacknowledged; i_enable=0 forces IDLE and drops pending pulses.
//
// Ports:
//   i_sys_clk, i_sys_rst  system clock, synchronous active-high reset
//   i_enable              level arm from the HDR engine
//   i_scl, i_sda          raw asynchronous bus lines
//   o_restart_det         pulse: HDR Restart
//   o_exit_det            pulse: HDR Exit followed by STOP
//   o_pattern_err         pulse: malformed pattern or timeout
//   o_busy                high while a pattern is being counted or the STOP is awaited
module hdr_exit_restart_ctrl
    import hdr_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_enable,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_restart_det,
    output logic o_exit_det,
    output logic o_pattern_err,
    output logic o_busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk  (i_sys_clk),
        .rst  (i_sys_rst),
        .line (i_scl),
        .s    (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    bus_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk  (i_sys_clk),
        .rst  (i_sys_rst),
        .line (i_sda),
        .s    (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    hdr_state_t        state;
    logic [FALL_W-1:0] falls;
    logic [TMO_W-1:0]  tmo;
    // Set after an Exit so IDLE stays put until the engine drops i_enable.
    logic              rearm_block;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state         <= IDLE;
            falls         <= '0;
            tmo           <= '0;
            rearm_block   <= 1'b0;
            o_restart_det <= 1'b0;
            o_exit_det    <= 1'b0;
            o_pattern_err <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_restart_det <= 1'b0;
            o_exit_det    <= 1'b0;
            o_pattern_err <= 1'b0;

            if (!i_enable) begin
                // Disarm wins over any decision made this cycle.
                state       <= IDLE;
                falls       <= '0;
                tmo         <= '0;
                rearm_block <= 1'b0;
                o_busy      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        o_busy <= 1'b0;
                        if (!rearm_block) begin
                            state <= ARMED;
                        end
                    end

                    ARMED: begin
                        o_busy <= 1'b0;
                        if (!scl_s && sda_s) begin
                            state  <= COUNT;
                            falls  <= '0;
                            tmo    <= '0;
                            o_busy <= 1'b1;
                        end
                    end

                    COUNT: begin
                        o_busy <= 1'b1;
                        // SCL edges take priority; a coincident SDA edge is dropped.
                        if (scl_rise) begin
                            state  <= ARMED;
                            o_busy <= 1'b0;
                            if (falls == RESTART_FALLS && sda_s) begin
                                o_restart_det <= 1'b1;
                            end else if (falls != '0) begin
                                o_pattern_err <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            tmo <= '0;
                        end else if (sda_rise || sda_fall) begin
                            tmo <= '0;
                            if (sda_fall && !scl_s) begin
                                falls <= falls + 3'd1;
                                if (falls == EXIT_FALLS - 3'd1) begin
                                    state <= EXIT_WAIT;
                                end
                            end
                        end else if (tmo == TMO_LAST) begin
                            state         <= ARMED;
                            o_pattern_err <= 1'b1;
                            o_busy        <= 1'b0;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end

                    EXIT_WAIT: begin
                        o_busy <= 1'b1;
                        if (scl_rise || scl_fall) begin
                            tmo <= '0;
                        end else if (sda_rise && scl_s) begin
                            // STOP completes the Exit; stay down until re-armed.
                            state       <= IDLE;
                            rearm_block <= 1'b1;
                            o_exit_det  <= 1'b1;
                            o_busy      <= 1'b0;
                        end else if (sda_rise || sda_fall) begin
                            // Extra falls are ignored; falls stays saturated.
                            tmo <= '0;
                        end else if (tmo == TMO_LAST) begin
                            state         <= ARMED;
                            o_pattern_err <= 1'b1;
                            o_busy        <= 1'b0;
                        end else begin
                            tmo <= tmo + 1'b1;
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdr_exit_restart_ctrl.sv
// Self-checking bench for hdr_exit_restart_ctrl: scoreboard of expected pulses.
// Latency: expected pulse cycle = drive cycle + SYNC_STAGES + 1 (+ timeout span).
// Backpressure: n/a.
module tb_hdr_exit_restart_ctrl;

    localparam int K_RST = 1;
    localparam int K_EXIT = 2;
    localparam int K_ERR = 3;
    localparam int LAT = 3;          // SYNC_STAGES + 1
    localparam int TMO_LAT = LAT + 255;

    logic i_sys_clk_tb = 1'b0;
    logic rst, en, scl, sda;
    logic restart_det, exit_det, pattern_err, busy;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;
    exp_t sb[$];

    hdr_exit_restart_ctrl #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (255),
        .TMO_W          (8)
    ) dut (
        .i_sys_clk     (i_sys_clk_tb),
        .i_sys_rst     (rst),
        .i_enable      (en),
        .i_scl         (scl),
        .i_sda         (sda),
        .o_restart_det (restart_det),
        .o_exit_det    (exit_det),
        .o_pattern_err (pattern_err),
        .o_busy        (busy)
    );

    always #5 i_sys_clk_tb = ~i_sys_clk_tb;
    always @(posedge i_sys_clk_tb) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_sys_clk_tb);
    endtask

    task automatic expect_pulse(input int kind, input int dly);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc + dly;
        sb.push_back(e);
    endtask

    task automatic pulse_sda(input int n);
        repeat (n) begin
            sda = 1'b0; tick(2);
            sda = 1'b1; tick(2);
        end
    endtask

    task automatic restart_seq();
        scl = 1'b0; tick(2);
        pulse_sda(2);
        scl = 1'b1;
        expect_pulse(K_RST, LAT);
        tick(6);
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        int kind;
        forever begin
            @(negedge i_sys_clk_tb);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_pulse", 0, 32'(e.kind));
            end
            if (restart_det || exit_det || pattern_err) begin
                chk("pulse_onehot", 32'($countones({restart_det, exit_det, pattern_err})), 1);
                kind = restart_det ? K_RST : (exit_det ? K_EXIT : K_ERR);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'(kind), 0);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 32'(kind), 32'(e.kind));
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, cycle %0d expected below 5000", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; scl = 1'b1; sda = 1'b1;
        tick(3);
        chk("reset_outputs", 32'({restart_det, exit_det, pattern_err, busy}), 0);
        rst = 1'b0;
        tick(2);
        chk("idle_outputs", 32'({restart_det, exit_det, pattern_err, busy}), 0);
        en = 1'b1;
        tick(2);

        // Restart, checking busy around it.
        scl = 1'b0; tick(3);
        chk("busy_in_count", 32'(busy), 1);
        pulse_sda(2);
        scl = 1'b1;
        expect_pulse(K_RST, LAT);
        tick(LAT);
        chk("busy_at_restart", 32'(busy), 0);
        tick(1);
        chk("busy_after_restart", 32'(busy), 0);
        tick(3);

        // Still armed: a second restart needs no re-enable.
        restart_seq();

        // Disarm in the deciding cycle suppresses the restart pulse.
        scl = 1'b0; tick(2);
        pulse_sda(2);
        scl = 1'b1; tick(2);
        en = 1'b0; tick(1);
        chk("busy_suppressed", 32'(busy), 0);
        en = 1'b1; tick(4);

        // Exit: four falls, SCL high, then STOP.
        scl = 1'b0; tick(2);
        pulse_sda(3);
        sda = 1'b0; tick(3);
        chk("busy_exit_wait", 32'(busy), 1);
        sda = 1'b1; tick(2);
        sda = 1'b0; tick(2);           // extra fall, ignored
        scl = 1'b1; tick(3);
        chk("busy_before_stop", 32'(busy), 1);
        sda = 1'b1;
        expect_pulse(K_EXIT, LAT);
        tick(LAT);
        chk("busy_after_exit", 32'(busy), 0);
        tick(3);

        // After Exit, stays idle until i_enable toggles.
        scl = 1'b0; tick(6);
        chk("no_rearm_busy", 32'(busy), 0);
        scl = 1'b1; tick(3);
        en = 1'b0; tick(2);
        en = 1'b1; tick(2);
        restart_seq();

        // Malformed: three falls, SDA low, SCL rises.
        scl = 1'b0; tick(2);
        pulse_sda(2);
        sda = 1'b0; tick(2);
        scl = 1'b1;
        expect_pulse(K_ERR, LAT);
        tick(4);
        sda = 1'b1; tick(4);

        // Two falls but SDA low at SCL rise is also malformed.
        scl = 1'b0; tick(2);
        pulse_sda(1);
        sda = 1'b0; tick(2);
        scl = 1'b1;
        expect_pulse(K_ERR, LAT);
        tick(4);
        sda = 1'b1; tick(4);

        // Coincident edges: the 4th SDA fall is dropped in favour of SCL rise.
        scl = 1'b0; tick(2);
        pulse_sda(3);
        sda = 1'b0; scl = 1'b1;
        expect_pulse(K_ERR, LAT);
        tick(4);
        chk("busy_after_coincident", 32'(busy), 0);
        sda = 1'b1; tick(4);

        // Timeout after a single fall.
        scl = 1'b0; tick(4);
        sda = 1'b0;
        expect_pulse(K_ERR, TMO_LAT);
        tick(TMO_LAT - 1);
        chk("busy_before_timeout", 32'(busy), 1);
        tick(1);
        chk("busy_after_timeout", 32'(busy), 0);
        sda = 1'b1; tick(3);
        scl = 1'b1; tick(4);

        // Abort: disarm after two falls; SCL rise produces nothing.
        scl = 1'b0; tick(2);
        sda = 1'b0; tick(2);
        sda = 1'b1; tick(2);
        sda = 1'b0; tick(2);
        en = 1'b0; tick(2);
        scl = 1'b1; tick(5);
        chk("busy_after_abort", 32'(busy), 0);
        sda = 1'b1; en = 1'b1; tick(4);

        // Reset while waiting for STOP: the STOP must not report an Exit.
        scl = 1'b0; tick(2);
        pulse_sda(3);
        sda = 1'b0; tick(2);
        scl = 1'b1; tick(4);
        chk("busy_pre_reset", 32'(busy), 1);
        rst = 1'b1; tick(1);
        chk("reset_mid_pattern", 32'({restart_det, exit_det, pattern_err, busy}), 0);
        rst = 1'b0; tick(1);
        sda = 1'b1; tick(6);
        chk("busy_after_reset_stop", 32'(busy), 0);

        tick(4);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hdr_exit_restart_ctrl.md
Name: hdr_exit_restart_ctrl

Overview:
Controller that arms and sequences HDR Exit / HDR Restart pattern detection on the I3C bus lines during HDR mode. It synchronizes SCL/SDA, counts SDA falling edges while SCL is held low, and classifies the result as Restart, Exit, or malformed pattern. It replaces the standalone restart detector enable/done pairing with one FSM that the HDR engine arms and that reports a single-cycle classified event back to that engine.

Parameters:
SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (min 2).
TIMEOUT_CYCLES, 255, max i_sys_clk cycles without any synchronized SCL/SDA edge while a pattern is in progress.
TMO_W, 8, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
i_sys_clk  input  1  system clock, all logic on rising edge
i_sys_rst  input  1  synchronous reset, active-high
i_enable  input  1  level; 1 = arm detection (HDR mode active), 0 = force IDLE
i_scl  input  1  raw SCL line (asynchronous)
i_sda  input  1  raw SDA line (asynchronous)
o_restart_det  output  1  1-cycle pulse: valid HDR Restart detected
o_exit_det  output  1  1-cycle pulse: valid HDR Exit plus STOP detected
o_pattern_err  output  1  1-cycle pulse: malformed pattern or timeout
o_busy  output  1  1 while in COUNT or EXIT_WAIT

Behaviour:
- Reset: synchronizer flops and edge-history flops = 1 (idle bus high); FSM = IDLE; fall counter = 0; timeout counter = 0; all outputs = 0.
- Synchronized lines scl_s/sda_s. Edges are computed from scl_s/sda_s against a 1-cycle-delayed copy: rise = s & ~prev, fall = ~s & prev.
- All outputs are registered. A pulse is asserted in the cycle after the deciding synchronized edge, i.e. SYNC_STAGES+1 cycles after the raw pin change is first sampled.
- FSM states: IDLE, ARMED, COUNT, EXIT_WAIT.
- IDLE: outputs 0. i_enable=1 -> ARMED.
- ARMED: if scl_s=0 and sda_s=1 -> COUNT, with falls=0 and tmo=0.
- COUNT: o_busy=1.
  - sda fall with scl_s=0: falls+1.
  - falls reaches 4 (EXIT_FALLS) -> EXIT_WAIT.
  - scl rise with falls=2 and sda_s=1: o_restart_det pulse -> ARMED.
  - scl rise with falls=0: silent return to ARMED (normal data clocking, no error).
  - scl rise with falls=1 or 3, or with falls=2 and sda_s=0: o_pattern_err -> ARMED.
- EXIT_WAIT: o_busy=1. Waits for STOP: sda rise while scl_s=1.
  - STOP seen: o_exit_det pulse -> IDLE. The HDR engine must re-arm by deasserting and then reasserting i_enable.
  - Additional sda falls while SCL is low are ignored (falls saturates at 4).
- Timeout (COUNT or EXIT_WAIT): tmo increments each cycle with no scl_s/sda_s edge and clears on any edge. Reaching TIMEOUT_CYCLES -> o_pattern_err -> ARMED.
- Simultaneous scl and sda edges in the same cycle: the SCL edge is evaluated and the SDA edge is discarded.
- i_enable=0 in any state -> IDLE on the next edge, no pulse issued. A pulse already scheduled for that cycle is suppressed.
- At most one of o_restart_det / o_exit_det / o_pattern_err is high in any cycle.
- Reset asserted mid-pattern: full return to reset values on the next clock, no pulse.

Decomposition:
- Package hdr_ctrl_pkg holds:
  - state enum (IDLE, ARMED, COUNT, EXIT_WAIT);
  - constants RESTART_FALLS=2, EXIT_FALLS=4;
  - 3-bit fall-counter width constant.
- Sub-module bus_line_sync (SYNC_STAGES flops plus prev flop; outputs s, rise, fall), instantiated once for SCL and once for SDA.
- FSM, counters and output registers live in hdr_exit_restart_ctrl.

Test Plan:
- Restart: period 10 ns, SYNC_STAGES=2, i_enable=1, SCL=0, SDA=1; toggle SDA every 20 ns (fall, rise, fall, rise), then raise SCL -> exactly one o_restart_det pulse 3 cycles after SCL rises; o_busy=0 next cycle; FSM back in ARMED.
- Exit: four SDA falls with SCL=0, then SCL=1, then SDA rises -> o_exit_det pulse 3 cycles after SDA rises; FSM IDLE; no o_pattern_err.
- Malformed: three SDA falls with SCL=0, SDA=0, then SCL rises -> o_pattern_err single pulse; no restart or exit pulse.
- Timeout: one SDA fall, then hold lines static for 255 cycles -> o_pattern_err on cycle 256 after last edge; o_busy drops.
- Abort: i_enable drops after two SDA falls; SCL then rises -> no pulse of any kind; FSM IDLE.
- Reset: i_sys_rst=1 for one cycle in EXIT_WAIT -> all outputs 0; the following STOP produces no o_exit_det.
